// File: rtl/pwm_seq_pkg.sv
// Shared constants for the PWM ramp sequencer.
// State encoding and the default datapath width.
package pwm_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int BOOT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2,
        ST_TRIP = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Duty command handshake between a controller and the sequencer.
// The controller is the master; the sequencer answers with Cmd_Ready.
interface pwm_ramp_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             Cmd_Valid;
    logic             Cmd_Ready;
    logic [WIDTH-1:0] Cmd_Duty_0;
    logic [WIDTH-1:0] Cmd_Duty_1;
    logic [WIDTH-1:0] Cmd_Duty_2;

    modport master (
        output Cmd_Valid,
        output Cmd_Duty_0,
        output Cmd_Duty_1,
        output Cmd_Duty_2,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid,
        input  Cmd_Duty_0,
        input  Cmd_Duty_1,
        input  Cmd_Duty_2,
        output Cmd_Ready
    );

endinterface

// File: rtl/pwm_slew_step.sv
// One phase: target register, slew-limited duty register, done flag.
// Duty moves only on i_tick and is clamped to the period at that tick.
module pwm_slew_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_zero,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic [WIDTH-1:0] i_cmd,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_done
);

    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_tgt;
    logic             r_done;

    logic [WIDTH:0]   w_d;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_p;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_mag;
    logic [WIDTH:0]   w_moved;
    logic             w_up;
    logic [WIDTH-1:0] w_cmd_c;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [WIDTH-1:0] w_duty_nxt;

    // Extra top bit keeps add/subtract free of wrap near full scale.
    always_comb begin
        w_d     = {1'b0, r_duty};
        w_t     = {1'b0, r_tgt};
        w_s     = {1'b0, i_step};
        w_p     = {1'b0, i_period};
        w_up    = (w_t > w_d);
        w_diff  = w_up ? (w_t - w_d) : (w_d - w_t);
        w_mag   = ((w_s == '0) || (w_diff < w_s)) ? w_diff : w_s;
        w_moved = w_up ? (w_d + w_mag) : (w_d - w_mag);
        w_cmd_c = (i_cmd > i_period) ? i_period : i_cmd;

        w_tgt_nxt = r_tgt;
        if (i_clr || i_zero) begin
            w_tgt_nxt = '0;
        end else if (i_load) begin
            w_tgt_nxt = w_cmd_c;
        end

        w_duty_nxt = r_duty;
        if (i_clr) begin
            w_duty_nxt = '0;
        end else if (i_tick) begin
            w_duty_nxt = (w_moved > w_p) ? i_period : w_moved[WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_duty <= '0;
            r_tgt  <= '0;
            r_done <= 1'b1;
        end else begin
            r_duty <= w_duty_nxt;
            r_tgt  <= w_tgt_nxt;
            r_done <= (w_duty_nxt == w_tgt_nxt);
        end
    end

    assign o_duty = r_duty;
    assign o_done = r_done;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Start/stop/trip sequencer for a 3-phase PWM with bootstrap charge
// and per-period slew-limited duty ramps.
module pwm_ramp_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Period,
    input  logic              Period_Tick,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Fault,
    input  logic              Fault_Clear,
    pwm_ramp_sequencer_if.slave cmd,
    input  logic [WIDTH-1:0]  Slew_Step,
    input  logic [BOOT_W-1:0] Boot_Periods,
    output logic [WIDTH-1:0]  Duty_0,
    output logic [WIDTH-1:0]  Duty_1,
    output logic [WIDTH-1:0]  Duty_2,
    output logic              Pwm_Enable,
    output logic              DeadTime_En,
    output logic [1:0]        State,
    output logic              Fault_Latched,
    output logic              Ramp_Done
);

    seq_state_t        r_state;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic              r_stop_pend;
    logic              r_fault_latched;

    seq_state_t        w_state_nxt;
    logic [BOOT_W-1:0] w_boot_nxt;
    logic              w_stop_nxt;
    logic [BOOT_W:0]   w_boot_inc;
    logic              w_boot_last;
    logic              w_duty_zero;
    logic              w_clr;
    logic              w_zero;
    logic              w_load;
    logic              w_tick;
    logic              w_ready;
    logic [2:0]        w_done;

    assign w_boot_inc  = {1'b0, r_boot_cnt} + 1'b1;
    assign w_boot_last = (w_boot_inc >= {1'b0, Boot_Periods});
    assign w_duty_zero = (Duty_0 == '0) && (Duty_1 == '0) && (Duty_2 == '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (Start && !Stop) w_state_nxt = ST_BOOT;
            ST_BOOT: begin
                if (Stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (Period_Tick && w_boot_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_stop_pend && Period_Tick && w_duty_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRIP: if (Fault_Clear && !Fault) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (Fault) w_state_nxt = ST_TRIP;
    end

    always_comb begin
        w_boot_nxt = '0;
        if ((r_state == ST_BOOT) && (w_state_nxt == ST_BOOT)) begin
            w_boot_nxt = Period_Tick ? w_boot_inc[BOOT_W-1:0] : r_boot_cnt;
        end
        w_stop_nxt = (w_state_nxt == ST_RUN) &&
                     (r_stop_pend || ((r_state == ST_RUN) && Stop));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_IDLE;
            r_boot_cnt      <= '0;
            r_stop_pend     <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_boot_cnt      <= w_boot_nxt;
            r_stop_pend     <= w_stop_nxt;
            r_fault_latched <= (w_state_nxt == ST_TRIP);
        end
    end

    // Phases hold zero in every state except a continuing RUN.
    assign w_ready = (r_state == ST_RUN) && !r_stop_pend;
    assign w_clr   = (w_state_nxt != ST_RUN);
    assign w_zero  = (r_state == ST_RUN) && Stop;
    assign w_load  = cmd.Cmd_Valid && w_ready;
    assign w_tick  = (r_state == ST_RUN) && Period_Tick;

    pwm_slew_step #(.WIDTH(WIDTH)) u_ph0 (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_clr    (w_clr),
        .i_zero   (w_zero),
        .i_load   (w_load),
        .i_tick   (w_tick),
        .i_cmd    (cmd.Cmd_Duty_0),
        .i_period (Period),
        .i_step   (Slew_Step),
        .o_duty   (Duty_0),
        .o_done   (w_done[0])
    );

    pwm_slew_step #(.WIDTH(WIDTH)) u_ph1 (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_clr    (w_clr),
        .i_zero   (w_zero),
        .i_load   (w_load),
        .i_tick   (w_tick),
        .i_cmd    (cmd.Cmd_Duty_1),
        .i_period (Period),
        .i_step   (Slew_Step),
        .o_duty   (Duty_1),
        .o_done   (w_done[1])
    );

    pwm_slew_step #(.WIDTH(WIDTH)) u_ph2 (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_clr    (w_clr),
        .i_zero   (w_zero),
        .i_load   (w_load),
        .i_tick   (w_tick),
        .i_cmd    (cmd.Cmd_Duty_2),
        .i_period (Period),
        .i_step   (Slew_Step),
        .o_duty   (Duty_2),
        .o_done   (w_done[2])
    );

    assign cmd.Cmd_Ready = w_ready;
    assign Pwm_Enable    = (r_state == ST_BOOT) || (r_state == ST_RUN);
    assign DeadTime_En   = Pwm_Enable;
    assign State         = r_state;
    assign Fault_Latched = r_fault_latched;
    assign Ramp_Done     = &w_done;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for the PWM ramp sequencer: boot, ramp, stop,
// trip, same-cycle command/tick and mid-ramp reset.
module tb_pwm_ramp_sequencer;

    logic        Clk;
    logic        Reset;
    logic [31:0] Period;
    logic        Period_Tick;
    logic        Start;
    logic        Stop;
    logic        Fault;
    logic        Fault_Clear;
    logic [31:0] Slew_Step;
    logic [15:0] Boot_Periods;
    logic [31:0] Duty_0;
    logic [31:0] Duty_1;
    logic [31:0] Duty_2;
    logic        Pwm_Enable;
    logic        DeadTime_En;
    logic [1:0]  State;
    logic        Fault_Latched;
    logic        Ramp_Done;

    int n_vec;
    int n_err;

    pwm_ramp_sequencer_if #(.WIDTH(32)) cmd_if ();

    pwm_ramp_sequencer #(.WIDTH(32)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Period        (Period),
        .Period_Tick   (Period_Tick),
        .Start         (Start),
        .Stop          (Stop),
        .Fault         (Fault),
        .Fault_Clear   (Fault_Clear),
        .cmd           (cmd_if),
        .Slew_Step     (Slew_Step),
        .Boot_Periods  (Boot_Periods),
        .Duty_0        (Duty_0),
        .Duty_1        (Duty_1),
        .Duty_2        (Duty_2),
        .Pwm_Enable    (Pwm_Enable),
        .DeadTime_En   (DeadTime_En),
        .State         (State),
        .Fault_Latched (Fault_Latched),
        .Ramp_Done     (Ramp_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        Period_Tick = 1'b1;
        cyc();
        Period_Tick = 1'b0;
    endtask

    task automatic gap();
        cyc();
        cyc();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic with_tick);
        cmd_if.Cmd_Valid  = 1'b1;
        cmd_if.Cmd_Duty_0 = a;
        cmd_if.Cmd_Duty_1 = b;
        cmd_if.Cmd_Duty_2 = c;
        Period_Tick       = with_tick;
        cyc();
        cmd_if.Cmd_Valid  = 1'b0;
        Period_Tick       = 1'b0;
    endtask

    task automatic duties(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c);
        chk({tag, ".d0"}, Duty_0, a);
        chk({tag, ".d1"}, Duty_1, b);
        chk({tag, ".d2"}, Duty_2, c);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        cyc();
        Start = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b1;
        Period = 32'd1000;
        Period_Tick = 1'b0;
        Start = 1'b0;
        Stop = 1'b0;
        Fault = 1'b0;
        Fault_Clear = 1'b0;
        Slew_Step = 32'd100;
        Boot_Periods = 16'd3;
        cmd_if.Cmd_Valid = 1'b0;
        cmd_if.Cmd_Duty_0 = '0;
        cmd_if.Cmd_Duty_1 = '0;
        cmd_if.Cmd_Duty_2 = '0;
        cyc();
        cyc();
        Reset = 1'b0;

        chk("rst.state", State, 0);
        chk("rst.pwm", Pwm_Enable, 0);
        chk("rst.dt", DeadTime_En, 0);
        chk("rst.rdy", cmd_if.Cmd_Ready, 0);
        chk("rst.flt", Fault_Latched, 0);
        chk("rst.done", Ramp_Done, 1);
        duties("rst", 0, 0, 0);

        // Stop alone and Start+Stop in IDLE are both no-ops
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        chk("idle.stop", State, 0);
        Start = 1'b1;
        Stop = 1'b1;
        cyc();
        Start = 1'b0;
        Stop = 1'b0;
        chk("idle.startstop", State, 0);

        // Bootstrap: three ticks
        pulse_start();
        chk("boot.state", State, 1);
        chk("boot.pwm", Pwm_Enable, 1);
        chk("boot.dt", DeadTime_En, 1);
        chk("boot.rdy", cmd_if.Cmd_Ready, 0);
        tick();
        gap();
        chk("boot.t1", State, 1);
        tick();
        gap();
        chk("boot.t2", State, 1);
        duties("boot.t2", 0, 0, 0);
        tick();
        chk("boot.t3", State, 2);
        chk("run.rdy", cmd_if.Cmd_Ready, 1);
        duties("run.entry", 0, 0, 0);

        // Slew-limited ramp; 1200 is clamped to 1000
        send(32'd350, 32'd1000, 32'd1200, 1'b0);
        chk("ramp.notdone", Ramp_Done, 0);
        duties("ramp.pretick", 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) duties("ramp.t1", 100, 100, 100);
            if (i == 3) chk("ramp.t3.d0", Duty_0, 300);
            if (i == 4) chk("ramp.t4.d0", Duty_0, 350);
            if (i == 9) begin
                duties("ramp.t9", 350, 900, 900);
                chk("ramp.t9.done", Ramp_Done, 0);
            end
            if (i == 10) begin
                duties("ramp.t10", 350, 1000, 1000);
                chk("ramp.t10.done", Ramp_Done, 1);
            end
            gap();
            if (i == 5) duties("ramp.hold", 350, 500, 500);
        end

        // Unlimited slew jumps on the next tick only
        Slew_Step = 32'd0;
        send(32'd500, 32'd250, 32'd0, 1'b0);
        cyc();
        duties("jump.pre", 350, 1000, 1000);
        tick();
        duties("jump", 500, 250, 0);
        chk("jump.done", Ramp_Done, 1);

        // Command on a tick steps toward the old targets
        Slew_Step = 32'd100;
        send(32'd800, 32'd800, 32'd800, 1'b1);
        duties("same.old", 500, 250, 0);
        tick();
        duties("same.new", 600, 350, 100);

        // Period cut takes effect at the next tick
        Period = 32'd550;
        gap();
        chk("pcut.hold", Duty_0, 600);
        tick();
        duties("pcut.tick", 550, 450, 200);
        Period = 32'd1000;

        // Stop ramp from 300s
        Slew_Step = 32'd0;
        send(32'd300, 32'd300, 32'd300, 1'b0);
        tick();
        duties("stop.start", 300, 300, 300);
        Slew_Step = 32'd100;
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        chk("stop.rdy", cmd_if.Cmd_Ready, 0);
        tick();
        duties("stop.t1", 200, 200, 200);
        tick();
        tick();
        duties("stop.t3", 0, 0, 0);
        chk("stop.t3.state", State, 2);
        tick();
        chk("stop.t4.state", State, 0);
        chk("stop.t4.pwm", Pwm_Enable, 0);

        // Zero boot periods: RUN on the first tick
        Boot_Periods = 16'd0;
        pulse_start();
        tick();
        chk("boot0.state", State, 2);

        // Fault mid-ramp
        send(32'd1000, 32'd1000, 32'd1000, 1'b0);
        tick();
        tick();
        duties("flt.pre", 200, 200, 200);
        Fault = 1'b1;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("flt.state", State, 3);
        chk("flt.pwm", Pwm_Enable, 0);
        chk("flt.dt", DeadTime_En, 0);
        chk("flt.latch", Fault_Latched, 1);
        chk("flt.rdy", cmd_if.Cmd_Ready, 0);
        duties("flt", 0, 0, 0);
        Fault_Clear = 1'b1;
        cyc();
        chk("flt.clr.held", State, 3);
        Fault = 1'b0;
        cyc();
        Fault_Clear = 1'b0;
        chk("flt.clr.state", State, 0);
        chk("flt.clr.latch", Fault_Latched, 0);

        // Stop in BOOT goes straight to IDLE
        Boot_Periods = 16'd2;
        pulse_start();
        tick();
        chk("bstop.boot", State, 1);
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        chk("bstop.idle", State, 0);

        // Boot counter restarts from zero after the aborted boot
        pulse_start();
        tick();
        chk("bcnt.t1", State, 1);
        tick();
        chk("bcnt.t2", State, 2);

        // Reset mid-ramp
        send(32'd900, 32'd900, 32'd900, 1'b0);
        tick();
        tick();
        duties("rst2.pre", 200, 200, 200);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        chk("rst2.state", State, 0);
        chk("rst2.pwm", Pwm_Enable, 0);
        chk("rst2.rdy", cmd_if.Cmd_Ready, 0);
        chk("rst2.done", Ramp_Done, 1);
        duties("rst2", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
